// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame path: pixel type, sequencer states,
// default latch time and the per-channel brightness scale.
package led_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    WAIT_DONE = 3'd3,
    LATCH     = 3'd4
  } seq_state_t;

  localparam int LATCH_CYCLES_DEFAULT = 5000;

  // (c * (brightness + 1)) >> 8 so that 255 is unity and 0 blanks the channel.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] brightness);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, brightness} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] brightness);
    return {scale8(p[23:16], brightness), scale8(p[15:8], brightness), scale8(p[7:0], brightness)};
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Frame buffer: DEPTH pixels, synchronous write and registered read (one-cycle latency).
// Out-of-range addresses are ignored on both ports.
module pixel_ram
  import led_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pixel_t mem_q [DEPTH];
  pixel_t rdata_q;

  // Block-RAM style array: no reset so it maps onto embedded memory.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem_q[waddr[IW-1:0]] <= wdata;
    end
    if (re && (32'(raddr) < DEPTH)) begin
      rdata_q <= mem_q[raddr[IW-1:0]];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Streams a buffered, brightness-scaled frame to led_driver one pixel at a time,
// then holds the line idle for the strip latch time and pulses frame_done.
module led_frame_sequencer
  import led_pkg::*;
#(
  parameter int N_LEDS       = 8,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
  parameter int AW           = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  input  logic          start,
  output logic [23:0]   rgb,
  output logic          load,
  input  logic          done,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_LEDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LATCH_CYCLES - 1);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pixel_t        rgb_q, rgb_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  pixel_t        rd_data_s;
  logic          rd_en_s;
  logic          done_ok_s;

  assign rd_en_s = (state_q == FETCH);
  // The driver cannot finish in the same cycle it is handed a pixel.
  assign done_ok_s = done && !load_q;

  pixel_ram #(
    .DEPTH (N_LEDS),
    .AW    (AW)
  ) u_pixel_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en_s),
    .raddr (idx_q),
    .rdata (rd_data_s)
  );

  // State, index, counter and all outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      rgb_q        <= 24'd0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rgb_q        <= rgb_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: start is refused while frame_done is still high.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !frame_done_q) begin
          state_d = FETCH;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_ok_s && (idx_q == LAST_IDX)) begin
          state_d = LATCH;
          cnt_d   = '0;
        end else if (done_ok_s) begin
          state_d = FETCH;
          idx_d   = idx_q + AW'(1);
        end else begin
          state_d = WAIT_DONE;
        end
      end
      LATCH: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the next cycle; rgb only changes on load or when latching.
  always_comb begin
    rgb_d        = rgb_q;
    load_d       = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      LOAD: begin
        rgb_d  = scale_pixel(rd_data_s, brightness);
        load_d = 1'b1;
      end
      WAIT_DONE: begin
        if (done_ok_s && (idx_q == LAST_IDX)) begin
          rgb_d = 24'd0;
        end else begin
          rgb_d = rgb_q;
        end
      end
      LATCH: begin
        rgb_d = 24'd0;
        if (cnt_q == LAST_CNT) begin
          frame_done_d = 1'b1;
        end else begin
          frame_done_d = 1'b0;
        end
      end
      default: begin
        rgb_d = rgb_q;
      end
    endcase
  end

  assign rgb        = rgb_q;
  assign load       = load_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: stimulus pushes expected pixels and
// frame completions, a monitor compares them whenever load or frame_done fires.
module tb_led_frame_sequencer;

  localparam int N  = 4;
  localparam int L  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [7:0]    brightness;
  logic          start;
  logic [23:0]   rgb;
  logic          load;
  logic          done_stub;
  logic          done_stray;
  logic          done;
  logic          busy;
  logic          frame_done;

  assign done = done_stub | done_stray;

  led_frame_sequencer #(
    .N_LEDS       (N),
    .LATCH_CYCLES (L),
    .AW           (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .brightness (brightness),
    .start      (start),
    .rgb        (rgb),
    .load       (load),
    .done       (done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cnt = 0;
  int fd_cnt = 0;
  int fd_expected = 0;
  int first_load_exp = -1;
  int last_done_edge = -1000;
  int remaining = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver stub: done pulse 30 cycles after every load.
  initial begin
    done_stub = 1'b0;
    forever begin
      @(negedge clk);
      done_stub = 1'b0;
      if (!rst) begin
        remaining = 0;
      end else begin
        if (remaining > 0) begin
          remaining--;
          if (remaining == 0) begin
            done_stub      = 1'b1;
            last_done_edge = cyc + 1;
          end
        end
        if (load) remaining = 30;
      end
    end
  end

  // Monitor: pops the scoreboard on load and frame_done.
  initial forever begin
    @(negedge clk);
    if (rst && load) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_load: rgb %06h while no pixel expected", rgb);
      end else begin
        check("rgb", rgb, exp_q.pop_front());
      end
      if (first_load_exp >= 0) begin
        check("first_load_latency", cyc, first_load_exp);
        first_load_exp = -1;
      end else begin
        check("next_load_latency", cyc - last_done_edge, 2);
      end
    end
    if (rst && frame_done) begin
      fd_cnt++;
      if (fd_expected == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame_done: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        fd_expected--;
        check("frame_done_latency", cyc - last_done_edge, L);
      end
    end
  end

  task automatic wr(input int a, input logic [23:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push4(input logic [23:0] e0, input logic [23:0] e1,
                       input logic [23:0] e2, input logic [23:0] e3);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    fd_expected++;
  endtask

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    first_load_exp = cyc + 3;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for frame_done (returns on that negedge), checking busy stays high.
  task automatic wait_fd(input string name);
    int n = 0;
    int low = 0;
    while (!frame_done && n < 600) begin
      if (!busy) low++;
      @(negedge clk);
      n++;
    end
    check({name, "_fd_timeout"}, 32'(n < 600), 32'd1);
    check({name, "_busy_low_cycles"}, low, 0);
  endtask

  task automatic wait_loads(input int target);
    int n = 0;
    while (load_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("load_wait_timeout", 32'(load_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fdbase;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 24'd0;
    brightness = 8'd255; start = 1'b0; done_stray = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rgb", rgb, 24'd0);
    check("reset_load", load, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    rst = 1'b1;

    // Basic frame at unity brightness
    wr(0, 24'h00CEFF); wr(1, 24'hFF0000); wr(2, 24'h00FF00); wr(3, 24'h0000FF);
    base = load_cnt;
    push4(24'h00CEFF, 24'hFF0000, 24'h00FF00, 24'h0000FF);
    start_frame();
    wait_fd("basic");
    check("basic_load_count", load_cnt - base, 4);

    // Scaling
    brightness = 8'd127;
    push4(24'h00677F, 24'h7F0000, 24'h007F00, 24'h00007F);
    start_frame();
    wait_fd("b127");
    brightness = 8'd0;
    push4(24'h000000, 24'h000000, 24'h000000, 24'h000000);
    start_frame();
    wait_fd("b0");
    brightness = 8'd255;

    // start while busy and in the frame_done cycle
    base = load_cnt; fdbase = fd_cnt;
    push4(24'h00CEFF, 24'hFF0000, 24'h00FF00, 24'h0000FF);
    start_frame();
    wait_loads(base + 1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fd("busy_start");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_busy", busy, 1'b0);
    check("ignored_start_loads", load_cnt - base, 4);
    check("ignored_start_frames", fd_cnt - fdbase, 1);

    // Mid-frame write and out-of-range write
    base = load_cnt;
    push4(24'h00CEFF, 24'hFF0000, 24'h00FF00, 24'h0000FF);
    start_frame();
    wait_loads(base + 3);
    wr(0, 24'h123456);
    wr(5, 24'hABCDEF);
    wait_fd("midwrite");
    push4(24'h123456, 24'hFF0000, 24'h00FF00, 24'h0000FF);
    start_frame();
    wait_fd("after_write");

    // Reset during pixel 1 WAIT_DONE, then stray done in IDLE
    base = load_cnt; fdbase = fd_cnt;
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'hFF0000);
    start_frame();
    wait_loads(base + 1);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!load && n < 100);
    end
    #2 rst = 1'b0;
    #1;
    check("midreset_rgb", rgb, 24'd0);
    check("midreset_load", load, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_frame_done", fd_cnt - fdbase, 0);
    check("abort_loads", load_cnt - base, 2);
    check("abort_queue_empty", exp_q.size(), 0);
    base = load_cnt;
    done_stray = 1'b1;
    @(negedge clk);
    done_stray = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_done_no_load", load_cnt - base, 0);
    check("stray_done_busy", busy, 1'b0);
    push4(24'h123456, 24'hFF0000, 24'h00FF00, 24'h0000FF);
    start_frame();
    wait_fd("after_reset");

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_fd_outstanding", fd_expected, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
Upstream stage feeding led_driver. It holds a frame of N_LEDS 24-bit pixels in a local buffer and applies a global brightness scale to each one. On start it streams the pixels one at a time to led_driver using the rgb/load/done handshake. After the last pixel it holds the line idle for the strip latch time, then pulses frame_done.

Parameters:
N_LEDS, 8, number of pixels per frame (>=1)
LATCH_CYCLES, 5000, idle clocks after the last pixel before frame_done (>=50 us at the system clock)
AW, $clog2(N_LEDS) (min 1), pixel address width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
wr_en  in  1  pixel buffer write strobe
wr_addr  in  AW  pixel index to write
wr_data  in  24  pixel value {c2,c1,c0}, passed to the driver in the same bit order
brightness  in  8  global scale, 255 = unity
start  in  1  request one frame transmission
rgb  out  24  pixel to led_driver
load  out  1  one-cycle load strobe to led_driver
done  in  1  led_driver one-cycle pulse: current pixel fully shifted out
busy  out  1  high from start acceptance until frame_done
frame_done  out  1  one-cycle pulse at end of latch period

Behaviour:
- Reset (rst low, asynchronous): state IDLE, rgb=0, load=0, busy=0, frame_done=0, pixel index=0, latch counter=0. Buffer contents are not reset.
- Buffer: N_LEDS x 24 with synchronous write and synchronous read (1-cycle latency).
  - Writes with wr_addr >= N_LEDS are dropped.
  - Writes are accepted in every state.
  - A pixel is sampled at its FETCH read, so a write to a pixel that was already sent takes effect next frame.
- Scaling, per channel: out = (c * (brightness+1)) >> 8, using a 16-bit product and truncating to 8 bits.
  - brightness=255 gives identity.
  - brightness=0 gives 0 for every c (255*1>>8 = 0).
- States:
  - IDLE: busy=0. start=1 -> FETCH, idx=0, busy=1 from the next cycle.
  - FETCH: present address idx for one cycle -> LOAD.
  - LOAD: rgb <= scaled read data. load=1 for exactly this one cycle -> WAIT_DONE.
  - WAIT_DONE: rgb held stable. On done: if idx==N_LEDS-1 go to LATCH with counter=0; else idx++ and go to FETCH.
  - LATCH: rgb=0, load=0, count up. When the counter reaches LATCH_CYCLES-1, assert frame_done for one cycle and return to IDLE with busy=0.
- Latency:
  - start sampled at edge k -> load high in cycle k+2.
  - done at edge d -> next load in cycle d+2.
  - Last done -> frame_done in cycle d+LATCH_CYCLES.
- start while busy: ignored (not queued). start in the same cycle frame_done is high: ignored. A new frame needs start in IDLE.
- done outside WAIT_DONE: ignored. done in the same cycle as load: ignored (the driver cannot finish in 0 cycles).
- N_LEDS=1: a single FETCH/LOAD/WAIT_DONE pass, then LATCH.
- rst asserted mid-frame: immediate return to reset values, load drops asynchronously, and there is no frame_done for the aborted frame.
- No timeout: a missing done holds WAIT_DONE indefinitely.

Decomposition:
- Shared package led_pkg:
  - typedef pixel_t (logic [23:0])
  - enum seq_state_t {IDLE, FETCH, LOAD, WAIT_DONE, LATCH}
  - default LATCH_CYCLES constant
  - function scale8(c, brightness)
- One sub-module, pixel_ram: N_LEDS x pixel_t, synchronous read/write, maps to EBR.
- The sequencer FSM, scaling and latch counter stay in led_frame_sequencer.

Test Plan:
Bench settings: N_LEDS=4, LATCH_CYCLES=8, driver stub returns done 30 cycles after each load.
1. Reset: rst low mid-sim -> rgb=0, load=0, busy=0, frame_done=0 within the same cycle.
2. Basic frame: write pixels 0..3 = 0x00CEFF, 0xFF0000, 0x00FF00, 0x0000FF with brightness=255, then pulse start.
   - Exactly 4 load pulses, rgb equal to those values in order.
   - First load 2 cycles after start.
   - frame_done exactly 8 cycles after the 4th done.
   - busy high throughout.
3. Scaling: brightness=127 on pixel 0x00CEFF -> 0x00677F. brightness=0 -> 0x000000 for every pixel.
4. start while busy: pulse start during WAIT_DONE and again in the frame_done cycle -> still only 4 loads, one frame_done, busy=0 afterwards.
5. Mid-frame write and bad address:
   - Write pixel 0 = 0x123456 while pixel 2 is in flight -> the current frame still sends the old pixel 0; the next frame sends 0x123456.
   - Write to wr_addr=5 -> no effect on the buffer.
6. Reset mid-frame and stray done: assert rst during pixel 1 WAIT_DONE -> no frame_done; the next start sends from pixel 0. A spurious done in IDLE -> no load.
